// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU compare sequencer.
//               Holds the operation encoding, the sequencer state encoding
//               and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Operation codes as seen on req_op
  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SLT  = 2'd2,
    OP_SLTU = 2'd3
  } alu_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_result.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_result
// Description : Combinational mapping from the shared adder's sum and flags
//               to the final result of the requested operation.
// Ports       : op          - operation being completed
//               sum         - adder result
//               neg/ovf/carry - adder flags (sum MSB, signed overflow,
//                               carry-out)
//               result      - mapped result word
//               result_zero - result equals zero
//               result_ovf  - overflow flag (ADD/SUB only)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_result
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] sum,
  input  logic             neg,
  input  logic             ovf,
  input  logic             carry,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             result_ovf
);

  always_comb begin
    result     = '0;
    result_ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result     = sum;
        result_ovf = ovf;
      end
      // a - b computed as a + ~b + 1: signed less-than is the true sign of
      // the difference, i.e. the sum MSB corrected by overflow.
      OP_SLT:  result[0] = neg ^ ovf;
      // No carry-out from a + ~b + 1 means a borrow occurred: a < b.
      OP_SLTU: result[0] = ~carry;
      default: result    = '0;
    endcase
  end

  assign result_zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_cmp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmp_sequencer
// Description : Sequences ADD/SUB/SLT/SLTU operations through an external
//               shared gate-delay adder/subtractor. A request is registered,
//               the adder is given SETTLE cycles to settle, the result is
//               captured once and held until the consumer accepts it.
// Ports       : clk, reset          - clock, async active-high reset
//               req_valid/req_ready - request handshake
//               req_op/req_a/req_b  - operation and operands
//               dp_a/dp_b/dp_sub    - operands and mode to the shared adder
//               dp_sum/dp_neg/dp_ovf/dp_carry - adder result and flags
//               rsp_valid/rsp_ready - response handshake
//               rsp_data/rsp_zero/rsp_ovf - result, zero and overflow
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmp_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 4            // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sub,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_neg,
  input  logic             dp_ovf,
  input  logic             dp_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovf
);

  localparam logic [3:0] c_cnt_load = 4'(SETTLE - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [3:0]       r_cnt;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_ovf;

  logic             w_accept;
  logic             w_settled;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_result;
  logic             w_result_zero;
  logic             w_result_ovf;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_settled  = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_next = ST_WAIT;
      ST_WAIT: if (w_settled)  w_state_next = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, settle counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= alu_op_e'(req_op);
        r_a   <= req_a;
        r_b   <= req_b;
        r_cnt <= c_cnt_load;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // The adder output is only trusted at this single edge; it may be
      // mid-transition at any other time.
      if (w_settled) begin
        r_rsp_data <= w_result;
        r_rsp_zero <= w_result_zero;
        r_rsp_ovf  <= w_result_ovf;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = (r_state == ST_RESP);
    dp_a      = '0;
    dp_b      = '0;
    dp_sub    = 1'b0;
    // Keep the shared adder quiet while no operation is in flight.
    if (r_state != ST_IDLE) begin
      dp_a   = r_a;
      dp_b   = r_b;
      dp_sub = (r_op != OP_ADD);
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_rsp_zero;
  assign rsp_ovf  = r_rsp_ovf;

  alu_seq_result #(
    .WIDTH (WIDTH)
  ) u_result (
    .op          (r_op),
    .sum         (dp_sum),
    .neg         (dp_neg),
    .ovf         (dp_ovf),
    .carry       (dp_carry),
    .result      (w_result),
    .result_zero (w_result_zero),
    .result_ovf  (w_result_ovf)
  );

endmodule
`default_nettype wire

// File: doc/alu_cmp_sequencer.md
ALU_CMP_SEQUENCER -- requirements
Module: alu_cmp_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, data width of operands and result.
REQ-002 Parameter SETTLE, default 4, cycles the shared gate-delay adder is given to settle; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_op  input  2  0=ADD, 1=SUB, 2=SLT (signed), 3=SLTU (unsigned).
REQ-008 req_a, req_b  input  WIDTH  operands.
REQ-009 dp_a, dp_b  output  WIDTH  operands driven to the shared adder/subtractor.
REQ-010 dp_sub  output  1  1 = datapath computes a + ~b + 1; 0 = a + b.
REQ-011 dp_sum  input  WIDTH  datapath result.
REQ-012 dp_neg, dp_ovf, dp_carry  input  1 each  datapath flags: sum MSB, signed overflow, carry-out.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  WIDTH  result.
REQ-016 rsp_zero, rsp_ovf  output  1 each  rsp_data==0; captured dp_ovf for ADD/SUB, 0 otherwise.

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready SHALL equal (state==IDLE).
REQ-018 IDLE: on req_valid&&req_ready, register req_op/req_a/req_b, load counter with SETTLE-1, go to WAIT; otherwise stay.
REQ-019 dp_a/dp_b/dp_sub SHALL be driven from registered operands only; dp_sub=1 for SUB, SLT, SLTU; all dp outputs 0 in IDLE.
REQ-020 WAIT: decrement counter each cycle; at the edge where counter==0, capture result and flags, go to RESP.
REQ-021 Result mapping: ADD/SUB -> dp_sum; SLT -> {0..., dp_neg ^ dp_ovf}; SLTU -> {0..., ~dp_carry}; bits WIDTH-1..1 zero for SLT/SLTU.
REQ-022 Latency: request accepted at edge k -> rsp_valid high from edge k+SETTLE onward.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_zero/rsp_ovf held stable until rsp_valid&&rsp_ready; then go to IDLE.
REQ-024 No request bypass: next request accepted no earlier than the cycle after the response handshake; throughput one op per SETTLE+2 cycles minimum.
REQ-025 req_valid while not IDLE SHALL be ignored without side effect; requester must hold it.
REQ-026 Datapath inputs SHALL be sampled only at the WAIT->RESP edge; changes at other times have no effect.
REQ-027 rsp_ready with rsp_valid low SHALL have no effect.

Reset
REQ-028 reset asserted SHALL immediately force state IDLE, counter 0, registered operands 0, rsp_valid/rsp_data/rsp_zero/rsp_ovf 0, dp outputs 0; req_ready=1 after release.
REQ-029 Reset during WAIT or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-030 Shared package alu_seq_pkg SHALL hold the op enum (ADD/SUB/SLT/SLTU), FSM state enum, and default WIDTH constant.
REQ-031 Flag-to-result mapping (REQ-021) SHALL be a combinational sub-module alu_seq_result; FSM and registers stay in the top module.

Verification
REQ-032 SLT a=0xFFFFFFFF(-1), b=1, SETTLE=4 -> rsp_data=1, rsp_valid at accept edge+4, rsp_ovf=0.
REQ-033 SLTU a=0xFFFFFFFF, b=1 -> rsp_data=0; SLTU a=1, b=0xFFFFFFFF -> rsp_data=1.
REQ-034 SLT a=0x80000000, b=1 (overflow case) -> rsp_data=1; ADD 0x7FFFFFFF+1 -> rsp_data=0x80000000, rsp_ovf=1.
REQ-035 SUB a=5, b=5 with rsp_ready low 3 cycles -> rsp_data=0, rsp_zero=1 held stable, req_ready=0 until handshake, second req_valid ignored meanwhile.
REQ-036 Assert reset during WAIT (cycle 2 of 4) -> all outputs 0 immediately, no rsp_valid; next request completes normally.
REQ-037 Back-to-back ops with rsp_ready=1 constant, SETTLE=1 -> one response every 3 cycles, results in request order.
